// File: rtl/dispatch_pkg.sv
// Shared types and sizing for the rename->dispatch stage.
// Optional build macro: DISPATCH_PERF_CNT_EN (see dispatch_stage).
package dispatch_pkg;

  localparam int unsigned DISPATCH_WIDTH = 2;
  localparam int unsigned NUM_IQ         = 4;
  localparam int unsigned CDB_PORTS      = 2;
  localparam int unsigned PREG_W         = 6;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned IQ_SEL_W       = $clog2(NUM_IQ);
  localparam int unsigned SRC_NUM        = 2 * DISPATCH_WIDTH;

  typedef enum logic [IQ_SEL_W-1:0] {IQ_ALU0, IQ_ALU1, IQ_LSU, IQ_MDU} iq_id_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [PREG_W-1:0] dest;
    logic [25:0]       ctrl;
  } disp_uop_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } cdb_pkg_t;

  // Tag 0 is the hardwired zero register and never matches a broadcast.
  function automatic logic cdb_hit(input cdb_pkg_t c, input logic [PREG_W-1:0] preg);
    return c.valid && (c.preg == preg) && (preg != '0);
  endfunction

endpackage

// File: rtl/dispatch_if.sv
// Dispatch bus from the stage to the issue queues: per-queue handshake plus
// the held bundle's masks, operands and uops shared by all queues.
interface dispatch_if #(
  parameter int unsigned DispatchWidth = dispatch_pkg::DISPATCH_WIDTH,
  parameter int unsigned NumIq         = dispatch_pkg::NUM_IQ
);
  import dispatch_pkg::*;

  localparam int unsigned SrcNum = 2 * DispatchWidth;

  logic [NumIq-1:0]                     valid;
  logic [NumIq-1:0]                     ready;
  logic [NumIq-1:0][DispatchWidth-1:0]  mask;
  logic [SrcNum-1:0]                    src_rdy;
  logic [SrcNum-1:0][DATA_W-1:0]        src_data;
  disp_uop_t [DispatchWidth-1:0]        uop;

  modport master (output valid, mask, src_rdy, src_data, uop, input ready);
  modport slave  (input valid, mask, src_rdy, src_data, uop, output ready);

endinterface

// File: rtl/dispatch_operand_slot.sv
// One source operand of the held bundle: tag, ready bit and data, filled at
// load time and completed from the CDB (lowest port first) or the ROB.
module dispatch_operand_slot import dispatch_pkg::*; #(
  parameter int unsigned CdbPorts = CDB_PORTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         hold,
  input  logic [PREG_W-1:0]            load_preg,
  input  logic                         load_rdy,
  input  logic [DATA_W-1:0]            load_data,
  input  cdb_pkg_t [CdbPorts-1:0]      cdb,
  input  logic                         rob_cpl,
  input  logic [DATA_W-1:0]            rob_data,
  output logic [PREG_W-1:0]            preg,
  output logic                         rdy,
  output logic [DATA_W-1:0]            data
);

  logic [PREG_W-1:0] preg_q, preg_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load_hit, held_hit;
  logic [DATA_W-1:0] load_hit_data, held_hit_data;

  always_comb begin
    load_hit      = 1'b0;
    load_hit_data = '0;
    held_hit      = 1'b0;
    held_hit_data = '0;
    // Walk high to low so the lowest matching port is the one that sticks.
    for (int c = int'(CdbPorts) - 1; c >= 0; c--) begin
      if (cdb_hit(cdb[c], load_preg)) begin
        load_hit      = 1'b1;
        load_hit_data = cdb[c].data;
      end
      if (cdb_hit(cdb[c], preg_q)) begin
        held_hit      = 1'b1;
        held_hit_data = cdb[c].data;
      end
    end

    preg_d = preg_q;
    rdy_d  = rdy_q;
    data_d = data_q;
    if (load) begin
      preg_d = load_preg;
      rdy_d  = load_rdy | load_hit | (load_preg == '0);
      data_d = load_hit ? load_hit_data : load_data;
    end else if (hold && !rdy_q) begin
      if (held_hit) begin
        rdy_d  = 1'b1;
        data_d = held_hit_data;
      end else if (rob_cpl) begin
        rdy_d  = 1'b1;
        data_d = rob_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preg_q <= '0;
      rdy_q  <= 1'b0;
      data_q <= '0;
    end else begin
      preg_q <= preg_d;
      rdy_q  <= rdy_d;
      data_q <= data_d;
    end
  end

  assign preg = preg_q;
  assign rdy  = rdy_q;
  assign data = data_q;

endmodule

// File: rtl/dispatch_stage.sv
// One-entry bundle buffer between rename and the issue queues / ROB with
// partial per-target acceptance. DISPATCH_PERF_CNT_EN adds stall/insts counters.
module dispatch_stage import dispatch_pkg::*; #(
  parameter int unsigned  DispatchWidth = DISPATCH_WIDTH,
  parameter int unsigned  NumIq         = NUM_IQ,
  parameter int unsigned  CdbPorts      = CDB_PORTS,
  localparam int unsigned IqSelW        = (NumIq > 1) ? $clog2(NumIq) : 1,
  localparam int unsigned SrcNum        = 2 * DispatchWidth
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DispatchWidth-1:0]            in_inst_valid_i,
  input  logic [DispatchWidth-1:0][IqSelW-1:0] in_iq_sel_i,
  input  logic [SrcNum-1:0][PREG_W-1:0]       in_src_preg_i,
  input  logic [SrcNum-1:0]                   in_src_rdy_i,
  input  logic [SrcNum-1:0][DATA_W-1:0]       in_src_data_i,
  input  disp_uop_t [DispatchWidth-1:0]       in_uop_i,
  input  logic [SrcNum-1:0][DATA_W-1:0]       rob_rd_data_i,
  input  logic [SrcNum-1:0]                   rob_rd_cpl_i,
  output logic [SrcNum-1:0][PREG_W-1:0]       rob_rd_preg_o,
  output logic                                rob_alloc_valid_o,
  input  logic                                rob_alloc_ready_i,
  input  logic [CdbPorts-1:0]                 cdb_valid_i,
  input  logic [CdbPorts-1:0][PREG_W-1:0]     cdb_preg_i,
  input  logic [CdbPorts-1:0][DATA_W-1:0]     cdb_data_i,
  dispatch_if.master                          iq
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                         stall_cycles_o,
  output logic [31:0]                         disp_insts_o
`endif
);

  logic                                 held_valid_q;
  logic [DispatchWidth-1:0]             inst_valid_q;
  logic [DispatchWidth-1:0][IqSelW-1:0] sel_q;
  disp_uop_t [DispatchWidth-1:0]        uop_q;
  logic [NumIq-1:0]                     done_q, need, xfer;
  logic [NumIq-1:0][DispatchWidth-1:0]  mask;
  logic                                 done_rob_q, need_rob, rob_xfer;
  logic                                 retire, accept;
  cdb_pkg_t [CdbPorts-1:0]              cdb;

  always_comb begin
    mask = '0;
    for (int q = 0; q < int'(NumIq); q++) begin
      for (int i = 0; i < int'(DispatchWidth); i++) begin
        mask[q][i] = inst_valid_q[i] && (sel_q[i] == IqSelW'(q));
      end
      need[q] = |mask[q];
    end
  end

  always_comb begin
    for (int c = 0; c < int'(CdbPorts); c++) begin
      cdb[c].valid = cdb_valid_i[c];
      cdb[c].preg  = cdb_preg_i[c];
      cdb[c].data  = cdb_data_i[c];
    end
  end

  assign need_rob          = |inst_valid_q;
  assign iq.valid          = {NumIq{held_valid_q}} & need & ~done_q;
  assign rob_alloc_valid_o = held_valid_q & need_rob & ~done_rob_q;
  assign xfer              = iq.valid & iq.ready;
  assign rob_xfer          = rob_alloc_valid_o & rob_alloc_ready_i;
  assign retire            = held_valid_q & (&(~need | done_q | xfer)) &
                             (~need_rob | done_rob_q | rob_xfer);
  assign in_ready_o        = ~flush_i & (~held_valid_q | retire);
  assign accept            = in_valid_i & in_ready_o;
  assign iq.mask           = mask;
  assign iq.uop            = uop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid_q <= 1'b0;
      inst_valid_q <= '0;
      sel_q        <= '0;
      uop_q        <= '0;
      done_q       <= '0;
      done_rob_q   <= 1'b0;
    end else if (flush_i) begin
      held_valid_q <= 1'b0;
      inst_valid_q <= '0;
      done_q       <= '0;
      done_rob_q   <= 1'b0;
    end else if (accept) begin
      // An all-invalid bundle is consumed but never becomes visible.
      held_valid_q <= |in_inst_valid_i;
      inst_valid_q <= in_inst_valid_i;
      sel_q        <= in_iq_sel_i;
      uop_q        <= in_uop_i;
      done_q       <= '0;
      done_rob_q   <= 1'b0;
    end else if (retire) begin
      held_valid_q <= 1'b0;
      inst_valid_q <= '0;
      done_q       <= '0;
      done_rob_q   <= 1'b0;
    end else if (held_valid_q) begin
      done_q       <= done_q | xfer;
      done_rob_q   <= done_rob_q | rob_xfer;
    end
  end

  for (genvar s = 0; s < SrcNum; s++) begin : g_src
    dispatch_operand_slot #(
      .CdbPorts (CdbPorts)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .hold      (held_valid_q),
      .load_preg (in_src_preg_i[s]),
      .load_rdy  (in_src_rdy_i[s]),
      .load_data (in_src_data_i[s]),
      .cdb       (cdb),
      .rob_cpl   (rob_rd_cpl_i[s]),
      .rob_data  (rob_rd_data_i[s]),
      .preg      (rob_rd_preg_o[s]),
      .rdy       (iq.src_rdy[s]),
      .data      (iq.src_data[s])
    );
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_q, insts_q, retire_cnt;
  logic [32:0] insts_sum;

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < int'(DispatchWidth); i++) begin
      retire_cnt = retire_cnt + 32'(inst_valid_q[i]);
    end
    insts_sum = {1'b0, insts_q} + {1'b0, retire_cnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      insts_q <= '0;
    end else begin
      if (held_valid_q && !retire && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (retire) insts_q <= insts_sum[32] ? '1 : insts_sum[31:0];
    end
  end

  assign stall_cycles_o = stall_q;
  assign disp_insts_o   = insts_q;
`endif

endmodule
